// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts out a left-aligned frame MSB-first and
// runs a run-length predictor that flags RUN_LEN identical consecutive bits.
module seq_pattern_tx #(
    parameter int WIDTH   = 16,
    parameter int LEN_W   = 5,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [LEN_W-1:0] len,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             expect_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [LEN_W-1:0] LP_WIDTH = LEN_W'(WIDTH);
    localparam logic [RC_W-1:0]  LP_RUN   = RC_W'(RUN_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Handshake: a frame is accepted on a clk edge where state is IDLE,
    // start is high and len is within 1..WIDTH; any other start is dropped.
    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_shreg;
    logic [LEN_W-1:0] r_cnt;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_expect;
    logic             r_done;
    logic             r_run_bit;
    logic [RC_W-1:0]  r_run_cnt;

    logic             w_len_ok;
    logic             w_bit;
    logic             w_same;
    logic [RC_W-1:0]  w_run_next;

    assign w_len_ok = (len != '0) && (len <= LP_WIDTH);
    assign w_bit    = r_shreg[WIDTH-1];
    assign w_same   = (r_run_cnt != '0) && (w_bit == r_run_bit);

    // Run counter saturates at RUN_LEN so long runs keep expect_out high.
    always_comb begin
        w_run_next = RC_W'(1);
        if (w_same) begin
            w_run_next = (r_run_cnt == LP_RUN) ? LP_RUN : r_run_cnt + RC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start && w_len_ok) w_next_state = S_SHIFT;
            S_SHIFT: if (r_cnt == LEN_W'(1)) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_expect    <= 1'b0;
            r_done      <= 1'b0;
            r_run_bit   <= 1'b0;
            r_run_cnt   <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    r_bit_valid <= 1'b0;
                    if (start && w_len_ok) begin
                        r_shreg <= din << (LP_WIDTH - len);
                        r_cnt   <= len;
                    end
                end
                S_SHIFT: begin
                    r_bit_out   <= w_bit;
                    r_bit_valid <= 1'b1;
                    r_shreg     <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt       <= r_cnt - LEN_W'(1);
                    r_run_bit   <= w_bit;
                    r_run_cnt   <= w_run_next;
                    r_expect    <= (w_run_next == LP_RUN);
                end
                default: begin
                    r_bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign expect_out = r_expect;
    assign done       = r_done;
    assign state      = r_state;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: hand-computed bit, expect, busy and
// done sequences for each frame scenario.
module tb_seq_pattern_tx;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] din;
    logic [4:0]  len;
    logic        bit_out;
    logic        bit_valid;
    logic        expect_out;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    int n_vec;
    int n_err;

    seq_pattern_tx #(.WIDTH(16), .LEN_W(5), .RUN_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .len        (len),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .expect_out (expect_out),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one frame and records what comes out over a len+4 sample window.
    // Sample 0 is taken just after the accepting edge E0. If inj_at >= 0 a
    // competing start (din=FFFF, len=8) is held for one cycle from that sample.
    task automatic run_frame(input logic [15:0] f_din, input logic [4:0] f_len,
                             input int inj_at,
                             output logic [31:0] bits, output logic [31:0] exps,
                             output int nbits, output int busy_cnt,
                             output int done_idx, output int done_cnt,
                             output int done_busy);
        bits = '0; exps = '0; nbits = 0; busy_cnt = 0;
        done_idx = -1; done_cnt = 0; done_busy = 0;
        din = f_din; len = f_len; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(f_len) + 4; i++) begin
            if (busy) busy_cnt++;
            if (bit_valid) begin
                bits = {bits[30:0], bit_out};
                exps = {exps[30:0], expect_out};
                nbits++;
            end
            if (done) begin
                done_cnt++;
                done_idx = i;
                if (busy) done_busy = 1;
            end
            if (i == inj_at) begin
                start = 1'b1; din = 16'hFFFF; len = 5'd8;
            end else if (i == inj_at + 1) begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; din = 16'hFFFF; len = 5'd8;
        repeat (3) tick();
        n_vec++;
        if ({bit_out, bit_valid, expect_out, busy, done, state} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_hold: outs=%b required 0000000", {bit_out, bit_valid, expect_out, busy, done, state});
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        n_vec++;
        if ({bit_out, bit_valid, expect_out, busy, done, state} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_release: outs=%b required 0000000", {bit_out, bit_valid, expect_out, busy, done, state});
        end
    endtask

    task automatic test_run_f0();
        logic [31:0] bits, exps;
        int nb, bc, di, dc, dbz;
        run_frame(16'h00F0, 5'd8, -1, bits, exps, nb, bc, di, dc, dbz);
        n_vec++;
        if (nb !== 8 || bits[7:0] !== 8'b1111_0000) begin
            n_err++; $display("FAIL f0_bits: n=%0d bits=%b required n=8 bits=11110000", nb, bits[7:0]);
        end
        n_vec++;
        if (exps[7:0] !== 8'b0001_0001) begin
            n_err++; $display("FAIL f0_expect: got %b required 00010001", exps[7:0]);
        end
        n_vec++;
        if (bc !== 9 || dc !== 1 || di !== 9 || dbz !== 0) begin
            n_err++; $display("FAIL f0_busy_done: busy=%0d done_cnt=%0d done_idx=%0d done_busy=%0d required 9 1 9 0", bc, dc, di, dbz);
        end
    endtask

    task automatic test_alternating();
        logic [31:0] bits, exps;
        int nb, bc, di, dc, dbz;
        run_frame(16'hA5A5, 5'd16, -1, bits, exps, nb, bc, di, dc, dbz);
        n_vec++;
        if (nb !== 16 || bits[15:0] !== 16'hA5A5) begin
            n_err++; $display("FAIL a5_bits: n=%0d bits=%h required n=16 bits=a5a5", nb, bits[15:0]);
        end
        n_vec++;
        if (exps[15:0] !== 16'h0000) begin
            n_err++; $display("FAIL a5_expect: got %b required all zero", exps[15:0]);
        end
        n_vec++;
        if (bc !== 17 || dc !== 1 || di !== 17) begin
            n_err++; $display("FAIL a5_busy_done: busy=%0d done_cnt=%0d done_idx=%0d required 17 1 17", bc, dc, di);
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] bits, exps;
        int nb, bc, di, dc, dbz;
        logic [4:0] bad_len [2];
        bad_len[0] = 5'd0;
        bad_len[1] = 5'd17;
        for (int k = 0; k < 2; k++) begin
            int seen;
            seen = 0;
            din = 16'hFFFF; len = bad_len[k]; start = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (state !== 2'd0 || bit_valid || done || busy) seen = 1;
            end
            start = 1'b0;
            n_vec++;
            if (seen !== 0) begin
                n_err++; $display("FAIL ignore_len%0d: activity=%0d required 0", bad_len[k], seen);
            end
        end
        run_frame(16'h000A, 5'd4, 2, bits, exps, nb, bc, di, dc, dbz);
        n_vec++;
        if (nb !== 4 || bits[3:0] !== 4'b1010) begin
            n_err++; $display("FAIL busy_start_bits: n=%0d bits=%b required n=4 bits=1010", nb, bits[3:0]);
        end
        n_vec++;
        if (dc !== 1 || di !== 5 || state !== 2'd0 || exps[3:0] !== 4'b0000) begin
            n_err++; $display("FAIL busy_start_end: done_cnt=%0d done_idx=%0d state=%0d exp=%b required 1 5 0 0000", dc, di, state, exps[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits, exps;
        int nb, bc, di, dc, dbz;
        run_frame(16'h0003, 5'd2, -1, bits, exps, nb, bc, di, dc, dbz);
        n_vec++;
        if (nb !== 2 || bits[1:0] !== 2'b11 || exps[1:0] !== 2'b00) begin
            n_err++; $display("FAIL span_a: n=%0d bits=%b exp=%b required 2 11 00", nb, bits[1:0], exps[1:0]);
        end
        run_frame(16'h0003, 5'd2, -1, bits, exps, nb, bc, di, dc, dbz);
        n_vec++;
        if (nb !== 2 || bits[1:0] !== 2'b11 || exps[1:0] !== 2'b01) begin
            n_err++; $display("FAIL span_b: n=%0d bits=%b exp=%b required 2 11 01", nb, bits[1:0], exps[1:0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] bits, exps;
        int nb, bc, di, dc, dbz;
        int got, seen_done;
        got = 0;
        din = 16'h0000; len = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            tick();
            if (bit_valid) got++;
        end
        n_vec++;
        if (got !== 3) begin
            n_err++; $display("FAIL mid_reset_wait: valid bits=%0d required 3", got);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bit_valid, busy, expect_out, state} !== 5'b0) begin
            n_err++; $display("FAIL mid_reset_async: valid/busy/exp/state=%b required 00000", {bit_valid, busy, expect_out, state});
        end
        seen_done = 0;
        repeat (2) begin
            tick();
            if (done) seen_done = 1;
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            if (done) seen_done = 1;
        end
        n_vec++;
        if (seen_done !== 0) begin
            n_err++; $display("FAIL mid_reset_done: done seen=%0d required 0", seen_done);
        end
        run_frame(16'h0000, 5'd4, -1, bits, exps, nb, bc, di, dc, dbz);
        n_vec++;
        if (nb !== 4 || bits[3:0] !== 4'b0000 || exps[3:0] !== 4'b0001) begin
            n_err++; $display("FAIL post_reset_frame: n=%0d bits=%b exp=%b required 4 0000 0001", nb, bits[3:0], exps[3:0]);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; start = 1'b0; din = '0; len = '0;
        #1;
        test_reset();
        test_run_f0();
        test_alternating();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the driving end of the 1-bit serial stream consumed by the run-of-four sequence detector.
- Loads a parallel word plus a bit count, then emits the bits MSB-first, one per clock, with a valid strobe.
- Runs an internal run-length predictor that flags when RUN_LEN identical bits have been sent. Benches and self-test logic use this flag as the golden value for the detector's output.

Parameters:
WIDTH, 16, maximum frame length in bits (1..16 supported)
LEN_W, 5, width of the len port; must hold the value WIDTH
RUN_LEN, 4, run length (identical consecutive bits) that raises expect_out

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset; one clock domain only
start  in  1  frame request, sampled on a clk edge while IDLE
din  in  WIDTH  frame data; bits din[len-1] down to din[0] are sent
len  in  LEN_W  number of bits to send, legal range 1..WIDTH
bit_out  out  1  serial data bit (registered)
bit_valid  out  1  bit_out carries a new bit this cycle (registered)
expect_out  out  1  predicted detector output for the current bit (registered)
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse after the last bit of a frame
state  out  2  FSM state for debug: IDLE=0, SHIFT=1, DONE=2

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, bit counter, run_bit and run_cnt all cleared.
  - bit_out=0, bit_valid=0, expect_out=0, done=0, busy=0.
  - Takes effect immediately, including mid-frame. The partial frame is dropped and no done pulse is produced.
- IDLE:
  - On an edge with start=1 and 1<=len<=WIDTH: load shreg = din << (WIDTH-len) (left-aligned), cnt = len, go to SHIFT. Call this edge E0.
  - start with len=0 or len>WIDTH is ignored; stay in IDLE.
  - done is cleared on the first edge in IDLE, so it is high for exactly one cycle.
- SHIFT, on each edge:
  - bit_out <= shreg[WIDTH-1]; bit_valid <= 1; shreg shifts left by 1 (zero fill); cnt <= cnt-1.
  - If cnt==1, go to DONE.
  - Bits are therefore valid in the cycles after edges E1..E_len.
- DONE, one edge: bit_valid <= 0, done <= 1, go to IDLE.
- busy is combinational from state: high for len+1 cycles, starting after E0. It is low in the cycle in which done is high.
- start while busy is ignored; there is no queueing. Back-to-back frames therefore have at least one idle cycle between them.
- bit_out holds its last value while bit_valid=0.
- Run predictor:
  - Updates only on edges that emit a bit.
  - If run_cnt!=0 and bit==run_bit: run_cnt <= min(run_cnt+1, RUN_LEN). Otherwise run_bit <= bit, run_cnt <= 1.
  - expect_out <= (next run_cnt == RUN_LEN), registered alongside bit_out. It is high in the same cycle as the RUN_LEN-th (and any later) identical bit.
  - run_bit and run_cnt persist across frames and are cleared only by reset. This matches a detector that is reset together with the transmitter and samples only valid bits.
  - expect_out holds its value while bit_valid=0.
- Width rules: cnt is LEN_W bits; shreg is WIDTH bits; run_cnt saturates and never wraps.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0 and state=0. Release -> outputs stay 0 until the first start edge.
2. din=16'h00F0, len=8, start for 1 cycle -> bit_out sequence 1,1,1,1,0,0,0,0 on 8 consecutive bit_valid cycles. expect_out is high on bit 4 and bit 8 only. done is high exactly 1 cycle after bit 8. busy is high for 9 cycles.
3. din=16'hA5A5, len=16 -> 16 bits 1010_0101_1010_0101. expect_out is never high. busy is high for 17 cycles, then a done pulse.
4. Illegal and ignored starts:
   - start with len=0 -> state stays 0, no bit_valid, no done.
   - start with len=17 -> same.
   - Frame in progress (len=4) with start=1 plus new din asserted mid-frame -> only the original 4 bits are sent.
5. Run spanning frames: frame A din=2'b11, len=2, then frame B din=2'b11, len=2 -> expect_out low for both bits of A and bit 1 of B, high on bit 2 of B.
6. Mid-frame reset: len=8 frame, drop reset after the 3rd valid bit -> bit_valid/busy/expect_out go 0 immediately and no done pulse. A new frame din=4'b0000, len=4 after release -> expect_out high only on its 4th bit, which proves the run state was cleared.
